parity_stream_checker: RTL and testbench



---
 rtl/parity_stream_checker.sv | 108 ++++++++++
 tb/tb_parity_stream_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/parity_stream_checker.sv
// parity_stream_checker: per-word parity plus framed running parity with expected-bit check and saturating error count
module parity_stream_checker #(
    parameter int WIDTH = 4,
    parameter int MAXLEN = 16,
    parameter int ERRW = 8,
    localparam int LENW = $clog2(MAXLEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LENW-1:0]  len,
    input  logic             mode,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic             expected,
    output logic             busy,
    output logic             y,
    output logic             y_valid,
    output logic             done,
    output logic             parity,
    output logic             err,
    output logic [ERRW-1:0]  errors
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t          state_q, state_d;
    logic [LENW-1:0] len_q, len_d, cnt_q, cnt_d;
    logic            mode_q, mode_d, acc_q, acc_d;
    logic            y_q, y_d, y_valid_q, y_valid_d, done_q, done_d;
    logic            parity_q, parity_d, err_q, err_d;
    logic [ERRW-1:0] errors_q, errors_d;
    logic            w, fin, fin_par;
    // A frame finishes either on a zero-length start in IDLE or on the last accepted word in ACCUM
    always_comb begin
        w = ^a;
        fin = (state_q == IDLE) ? (start && len == '0) : (valid && (cnt_q + LENW'(1)) == len_q);
        fin_par = (state_q == IDLE) ? mode : (acc_q ^ w ^ mode_q);
    end
    // Next-state logic for the frame FSM and all registered outputs
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        cnt_d = cnt_q;
        mode_d = mode_q;
        acc_d = acc_q;
        y_d = y_q;
        y_valid_d = 1'b0;
        done_d = 1'b0;
        parity_d = parity_q;
        err_d = err_q;
        errors_d = errors_q;
        if (state_q == IDLE) begin
            if (start && len != '0) begin
                state_d = ACCUM;
                len_d = (len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : len;
                mode_d = mode;
                acc_d = 1'b0;
                cnt_d = '0;
            end
        end else if (valid) begin
            acc_d = acc_q ^ w;
            cnt_d = cnt_q + LENW'(1);
            y_d = w;
            y_valid_d = 1'b1;
            state_d = fin ? IDLE : ACCUM;
        end
        if (fin) begin
            done_d = 1'b1;
            parity_d = fin_par;
            err_d = fin_par ^ expected;
            errors_d = errors_q + ERRW'((fin_par ^ expected) && (errors_q != {ERRW{1'b1}}));
        end
    end
    // State and output registers; reset aborts any frame without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q <= '0;
            cnt_q <= '0;
            mode_q <= 1'b0;
            acc_q <= 1'b0;
            y_q <= 1'b0;
            y_valid_q <= 1'b0;
            done_q <= 1'b0;
            parity_q <= 1'b0;
            err_q <= 1'b0;
            errors_q <= '0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            mode_q <= mode_d;
            acc_q <= acc_d;
            y_q <= y_d;
            y_valid_q <= y_valid_d;
            done_q <= done_d;
            parity_q <= parity_d;
            err_q <= err_d;
            errors_q <= errors_d;
        end
    end
    assign busy = (state_q == ACCUM);
    assign y = y_q;
    assign y_valid = y_valid_q;
    assign done = done_q;
    assign parity = parity_q;
    assign err = err_q;
    assign errors = errors_q;
endmodule

// File: tb/tb_parity_stream_checker.sv
// tb_parity_stream_checker: directed test-plan frames plus random traffic against a frame-level reference model
module tb_parity_stream_checker;
    logic       clk, reset, start, mode, valid, expected;
    logic [4:0] len;
    logic [3:0] a;
    logic       busy, y, y_valid, done, parity, err;
    logic [7:0] errors;
    int         total = 0, passed = 0;
    bit         armed = 0;
    bit         m_busy, m_fmode, m_y, m_yv, m_done, m_par, m_err;
    int         m_ones, m_n, m_flen, m_errors;

    parity_stream_checker dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .mode(mode),
        .valid(valid), .a(a), .expected(expected), .busy(busy), .y(y),
        .y_valid(y_valid), .done(done), .parity(parity), .err(err), .errors(errors)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d at %0t", nm, got, exp, $time);
    endtask

    task automatic step(input bit rs, input bit st, input int l, input bit md, input bit v, input int aa, input bit ex);
        reset = rs; start = st; len = 5'(l); mode = md; valid = v; a = 4'(aa); expected = ex;
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: counts ones over the frame and counts words against the clamped length
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_y = 0; m_yv = 0; m_done = 0; m_par = 0; m_err = 0;
            m_errors = 0; m_ones = 0; m_n = 0; m_flen = 0; m_fmode = 0;
            armed = 1;
        end else begin
            m_yv = 0;
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    if (len == 0) begin
                        m_done = 1; m_par = mode; m_err = mode ^ expected;
                        if (m_err && m_errors < 255) m_errors++;
                    end else begin
                        m_busy = 1; m_flen = (len > 16) ? 16 : int'(len);
                        m_fmode = mode; m_ones = 0; m_n = 0;
                    end
                end
            end else if (valid) begin
                m_ones += $countones(a);
                m_n++;
                m_y = ($countones(a) & 1) == 1;
                m_yv = 1;
                if (m_n == m_flen) begin
                    m_busy = 0; m_done = 1;
                    m_par = ((m_ones & 1) == 1) ^ m_fmode;
                    m_err = m_par ^ expected;
                    if (m_err && m_errors < 255) m_errors++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, m_busy);
            chk("y", y, m_y);
            chk("y_valid", y_valid, m_yv);
            chk("done", done, m_done);
            chk("parity", parity, m_par);
            chk("err", err, m_err);
            chk("errors", errors, m_errors);
        end
    end

    initial begin
        int w4[4] = '{1, 3, 7, 15};
        int ye[4] = '{1, 0, 1, 0};
        int l;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y", y, 0);
        chk("rst_done", done, 0);
        chk("rst_errors", errors, 0);
        step(0, 1, 4, 0, 0, 0, 0);
        chk("s1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, w4[i], 0);
            chk("s1_y", y, ye[i]);
            chk("s1_yv", y_valid, 1);
        end
        chk("s1_done", done, 1);
        chk("s1_parity", parity, 0);
        chk("s1_err", err, 0);
        chk("s1_errors", errors, 0);
        chk("s1_busy_end", busy, 0);
        step(0, 1, 4, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 3, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_errors", errors, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 1);
        chk("post_rst_parity", parity, 1);
        chk("post_rst_err", err, 0);
        for (int r = 0; r < 2; r++) begin
            step(0, 1, 4, 1, 0, 0, 0);
            for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, w4[i], 0);
            chk("s2_parity", parity, 1);
            chk("s2_err", err, 1);
            chk("s2_errors", errors, r + 1);
        end
        step(0, 1, 0, 1, 0, 0, 1);
        chk("len0_done", done, 1);
        chk("len0_parity", parity, 1);
        chk("len0_err", err, 0);
        chk("len0_busy", busy, 0);
        step(0, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 12, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("gap_busy", busy, 1);
        step(0, 0, 0, 0, 1, 14, 0);
        chk("gap_done", done, 1);
        chk("gap_parity", parity, 0);
        chk("gap_err", err, 0);
        chk("gap_errors", errors, 2);
        for (int r = 0; r < 260; r++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 1, 1, 0);
            chk("sat_err", err, 1);
        end
        chk("sat_errors", errors, 255);
        step(0, 1, 20, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 1, 1);
        chk("clamp_done", done, 1);
        chk("clamp_parity", parity, 0);
        for (int c = 0; c < 3000; c++) begin
            l = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 6);
            step($urandom % 150 == 0, $urandom % 4 == 0, l, 1'($urandom), $urandom % 3 != 0,
                 int'($urandom % 16), 1'($urandom));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
